// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for a settled PLL lock, then runs the h/v counters and
// drives registered, mutually aligned sync/de/coordinate outputs.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic          lk_meta_q, lk_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   h_q, h_d, v_q, v_d;

  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic          line_q, line_d, frame_q, frame_d, run_q, run_d;
  logic [11:0]   x_q, x_d, y_q, y_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= locked;
      lk_q      <= lk_meta_q;
    end
  end

  // The WAIT_LOCK cycle that first sees lk=1 is already the first settle cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = '0;
        if (lk_q) begin
          if (LOCK_WAIT <= 1) begin
            state_d = S_RUN;
            h_d     = '0;
            v_d     = '0;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = CW'(1);
          end
        end
      end
      S_SETTLE: begin
        if (!lk_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_WAIT - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          h_d     = '0;
          v_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (!lk_q) begin
          state_d = S_WAIT;
          h_d     = '0;
          v_d     = '0;
        end else if (h_q == 12'(H_TOTAL - 1)) begin
          h_d = '0;
          v_d = (v_q == 12'(V_TOTAL - 1)) ? 12'd0 : v_q + 12'd1;
        end else begin
          h_d = h_q + 12'd1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Output decode gates on lk directly so a lost lock idles the outputs one cycle earlier.
  always_comb begin
    de_d    = 1'b0;
    hsync_d = ~HSYNC_POL;
    vsync_d = ~VSYNC_POL;
    x_d     = '0;
    y_d     = '0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    run_d   = 1'b0;
    if (state_q == S_RUN && lk_q) begin
      de_d    = ({1'b0, h_q} < 13'(H_ACTIVE)) && ({1'b0, v_q} < 13'(V_ACTIVE));
      hsync_d = (({1'b0, h_q} >= 13'(H_ACTIVE + H_FP)) &&
                 ({1'b0, h_q} <  13'(H_ACTIVE + H_FP + H_SYNC))) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = (({1'b0, v_q} >= 13'(V_ACTIVE + V_FP)) &&
                 ({1'b0, v_q} <  13'(V_ACTIVE + V_FP + V_SYNC))) ? VSYNC_POL : ~VSYNC_POL;
      x_d     = h_q;
      y_d     = v_q;
      line_d  = (h_q == 12'd0);
      frame_d = (h_q == 12'd0) && (v_q == 12'd0);
      run_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      x_q     <= '0;
      y_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      run_q   <= run_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign running     = run_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x7 raster with a 4-cycle lock settle.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        locked;
  logic        hsync, vsync, de, line_start, frame_start, running;
  logic [11:0] x, y;

  int checks = 0;
  int errors = 0;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_WAIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".running"}, running, 0);
    chk({tag, ".de"}, de, 0);
    chk({tag, ".hsync"}, hsync, 1);
    chk({tag, ".vsync"}, vsync, 1);
    chk({tag, ".x"}, x, 0);
    chk({tag, ".y"}, y, 0);
    chk({tag, ".line_start"}, line_start, 0);
    chk({tag, ".frame_start"}, frame_start, 0);
  endtask

  // Steps 1..6 must stay idle; step 7 must be the first pixel of a frame.
  task automatic chk_start(input string tag);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k < 7) chk({tag, ".pre_running"}, running, 0);
    end
    chk({tag, ".frame_start"}, frame_start, 1);
    chk({tag, ".line_start"}, line_start, 1);
    chk({tag, ".running"}, running, 1);
    chk({tag, ".de"}, de, 1);
    chk({tag, ".x"}, x, 0);
    chk({tag, ".y"}, y, 0);
    $display("%s: frame start observed at t=%0t", tag, $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int de_cnt[3];
    int fs_cnt, ls_cnt, ex, ey;

    // Reset with locked high throughout
    rst_n  = 1'b0;
    locked = 1'b1;
    step(); step(); step();
    chk_idle("reset");
    rst_n = 1'b1;
    chk_start("first_start");

    // Free-run three frames plus a little, against a hand model of the raster
    de_cnt = '{0, 0, 0};
    fs_cnt = 0;
    ls_cnt = 0;
    for (int cyc = 0; cyc <= 325; cyc++) begin
      ex = cyc % 14;
      ey = (cyc / 14) % 7;
      chk("run.x", x, ex);
      chk("run.y", y, ey);
      chk("run.de", de, (ex < 8 && ey < 4) ? 1 : 0);
      chk("run.hsync", hsync, (ex == 10 || ex == 11) ? 0 : 1);
      chk("run.vsync", vsync, (ey == 5) ? 0 : 1);
      chk("run.line_start", line_start, (ex == 0) ? 1 : 0);
      chk("run.frame_start", frame_start, (ex == 0 && ey == 0) ? 1 : 0);
      if (cyc < 294) begin
        if (de === 1'b1) de_cnt[cyc / 98]++;
        if (frame_start === 1'b1) fs_cnt++;
        if (line_start === 1'b1) ls_cnt++;
      end
      if (cyc < 325) step();
    end
    for (int f = 0; f < 3; f++) chk("de_per_frame", de_cnt[f], 32);
    chk("frame_start_count", fs_cnt, 3);
    chk("line_start_count", ls_cnt, 21);
    $display("run: 3 frames checked, de counts %0d/%0d/%0d", de_cnt[0], de_cnt[1], de_cnt[2]);

    // Lock drop at x=3,y=2: two more live pixels, then idle
    locked = 1'b0;
    step();
    chk("drop1.running", running, 1);
    chk("drop1.x", x, 4);
    step();
    chk("drop2.running", running, 1);
    chk("drop2.x", x, 5);
    step();
    chk_idle("drop3");
    locked = 1'b1;
    chk_start("relock");

    // Lock glitch 1,1,0 during settle restarts the count
    locked = 1'b0;
    step(); step(); step(); step();
    chk_idle("unlock");
    locked = 1'b1;
    step();
    chk("glitch_a1.running", running, 0);
    step();
    chk("glitch_a2.running", running, 0);
    locked = 1'b0;
    step();
    chk("glitch_a3.running", running, 0);
    locked = 1'b1;
    chk_start("glitch");

    // One-cycle reset mid-line
    step(); step(); step();
    chk("pre_reset.x", x, 3);
    rst_n = 1'b0;
    step();
    chk_idle("mid_reset");
    rst_n = 1'b1;
    chk_start("after_reset");
    step();
    chk("after_reset.x1", x, 1);
    chk("after_reset.line_start", line_start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
